// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared encodings and defaults for the 8N1 UART receiver
package uart_rx_pkg;

    localparam int RX_DATA_W         = 8;
    localparam int RX_OVERSAMPLE_DEF = 16;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    // BREAK is deliberately excluded: a held-low line is not an active frame.
    function automatic logic rx_state_busy(input logic [2:0] st);
        return (st == RX_START) || (st == RX_DATA) || (st == RX_STOP);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receive-side byte output bundle toward the RAM-write logic
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [RX_DATA_W-1:0] rx_data_o;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_busy;

    modport master (
        output rx_data_o,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data_o,
        input rx_valid,
        input rx_frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an idle-high asynchronous pin
module uart_rx_sync (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s
);

    logic meta_r;

    // Reset to 1 so a reset release never looks like a start edge.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            meta_r <= rxd;
            rxd_s  <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on a 16x oversampled baud tick
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = RX_OVERSAMPLE_DEF
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       bps16_clk_up,
    input  logic       rxd,
    uart_rx_if.master  rx_bus
);

    localparam int             TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0]  TICK_1  = TW'(1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end

    logic                 rxd_s;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [2:0]           bit_cnt;
    logic [RX_DATA_W-1:0] shift_r;
    logic [RX_DATA_W-1:0] data_r;
    logic                 valid_r;
    logic                 frame_err_r;

    uart_rx_sync u_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .rxd_s   (rxd_s)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_r     <= '0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (bps16_clk_up && !rxd_s) begin
                        tick_cnt <= '0;
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (bps16_clk_up) begin
                        if (tick_cnt == HALF_M1) begin
                            // Re-check at mid start bit to reject glitches.
                            if (rxd_s) begin
                                state <= RX_IDLE;
                            end else begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= RX_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_1;
                        end
                    end
                end
                RX_DATA: begin
                    if (bps16_clk_up) begin
                        if (tick_cnt == FULL_M1) begin
                            shift_r  <= {rxd_s, shift_r[RX_DATA_W-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_1;
                        end
                    end
                end
                RX_STOP: begin
                    if (bps16_clk_up) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            if (rxd_s) begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                                state   <= RX_IDLE;
                            end else begin
                                frame_err_r <= 1'b1;
                                state       <= RX_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_1;
                        end
                    end
                end
                RX_BREAK: begin
                    if (bps16_clk_up && rxd_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign rx_bus.rx_data_o    = data_r;
    assign rx_bus.rx_valid     = valid_r;
    assign rx_bus.rx_frame_err = frame_err_r;
    assign rx_bus.rx_busy      = rx_state_busy(state);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    logic sys_clk      = 1'b0;
    logic rst_n        = 1'b0;
    logic bps16_clk_up = 1'b0;
    logic rxd          = 1'b1;

    uart_rx_if rx_bus ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .bps16_clk_up (bps16_clk_up),
        .rxd          (rxd),
        .rx_bus       (rx_bus)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            bps16_clk_up = (c == 3);
            c = (c + 1) % 4;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed behaviour, sampled on the falling edge
    int         valid_cnt   = 0;
    int         err_cnt     = 0;
    int         busy_cnt    = 0;
    int         overlap_cnt = 0;
    int         glitch_cnt  = 0;
    logic [7:0] prev_data   = 8'h00;
    logic [7:0] got_q[$];

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_data = rx_bus.rx_data_o;
        end else begin
            if (rx_bus.rx_valid) begin
                valid_cnt++;
                got_q.push_back(rx_bus.rx_data_o);
            end
            if (rx_bus.rx_frame_err) err_cnt++;
            if (rx_bus.rx_valid && rx_bus.rx_frame_err) overlap_cnt++;
            if (rx_bus.rx_data_o !== prev_data && !rx_bus.rx_valid) glitch_cnt++;
            if (rx_bus.rx_busy) busy_cnt++;
            prev_data = rx_bus.rx_data_o;
        end
    end

    // Frame-level reference model
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_err  = 0;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
        rxd = 1'b0;
        wait_clks(period);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clks(period);
        end
        rxd = stop_bit;
        wait_clks(period);
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic compare_queue(input string tag);
        check_eq({tag, " count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, " byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " data"},  rx_bus.rx_data_o,    8'h00);
        check_eq({tag, " valid"}, rx_bus.rx_valid,     1'b0);
        check_eq({tag, " ferr"},  rx_bus.rx_frame_err, 1'b0);
        check_eq({tag, " busy"},  rx_bus.rx_busy,      1'b0);
    endtask

    initial begin
        int v0;
        int e0;
        logic [7:0] b;
        int period;
        bit bad;

        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(20);

        // Good frame; busy spans 8 + 128 + 16 ticks of 4 clocks
        busy_cnt = 0;
        send_frame(8'hA5, 64, 1'b1);
        wait_clks(32);
        check_eq("good data", rx_bus.rx_data_o, exp_data);
        check_eq("good busy cycles", busy_cnt, 608);
        compare_queue("good");

        // False start: low for 3 ticks only
        v0 = valid_cnt;
        e0 = err_cnt;
        rxd = 1'b0;
        wait_clks(12);
        rxd = 1'b1;
        wait_clks(32);
        check_eq("false start busy", rx_bus.rx_busy, 1'b0);
        check_eq("false start valid", valid_cnt, v0);
        check_eq("false start ferr", err_cnt, e0);

        // Framing error, line held low for 3 more bit times
        v0 = valid_cnt;
        send_frame(8'h3C, 64, 1'b0);
        wait_clks(3 * 64);
        check_eq("ferr count", err_cnt, exp_err);
        check_eq("ferr data kept", rx_bus.rx_data_o, exp_data);
        check_eq("ferr no valid", valid_cnt, v0);
        check_eq("ferr busy in break", rx_bus.rx_busy, 1'b0);
        rxd = 1'b1;
        wait_clks(64);
        send_frame(8'h42, 64, 1'b1);
        wait_clks(32);
        check_eq("recovery data", rx_bus.rx_data_o, exp_data);
        compare_queue("recovery");

        // Back-to-back frames with zero idle gap
        send_frame(8'h00, 64, 1'b1);
        send_frame(8'hFF, 64, 1'b1);
        send_frame(8'h55, 64, 1'b1);
        wait_clks(32);
        compare_queue("b2b");

        // Reset asserted in the middle of data bit 4, held until the frame is gone
        fork
            send_frame(8'h81, 64, 1'b1);
            begin
                wait_clks(64 * 5 + 32);
                rst_n = 1'b0;
                wait_clks(2);
                check_reset_outputs("mid reset");
            end
        join
        void'(exp_q.pop_back());
        exp_data = 8'h00;
        wait_clks(8);
        rst_n = 1'b1;
        wait_clks(64);
        check_eq("post reset data", rx_bus.rx_data_o, exp_data);
        send_frame(8'h7E, 64, 1'b1);
        wait_clks(32);
        check_eq("after reset data", rx_bus.rx_data_o, exp_data);
        check_eq("after reset ferr", err_cnt, exp_err);
        compare_queue("reset");

        // Baud tolerance at -3% and +3%
        send_frame(8'h96, 62, 1'b1);
        wait_clks(40);
        send_frame(8'h96, 66, 1'b1);
        wait_clks(32);
        check_eq("tol ferr", err_cnt, exp_err);
        compare_queue("tol");

        // Randomized frames, rates and occasional bad stop bits
        for (int n = 0; n < 24; n++) begin
            b      = 8'($urandom);
            period = $urandom_range(62, 66);
            bad    = ($urandom_range(0, 7) == 0);
            send_frame(b, period, !bad);
            rxd = 1'b1;
            if (bad) wait_clks($urandom_range(16, 80));
            else     wait_clks($urandom_range(0, 40));
        end
        wait_clks(32);
        check_eq("rand ferr", err_cnt, exp_err);
        check_eq("rand last data", rx_bus.rx_data_o, exp_data);
        compare_queue("rand");

        check_eq("valid/ferr overlap", overlap_cnt, 0);
        check_eq("data change without valid", glitch_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
